// File: rtl/bus_interconnect.sv
// bus_interconnect: two masters, NUM_SLAVES window-decoded slaves, one outstanding transaction per master.
// Request and response paths add 0 cycles; decode error answers the next cycle. Losing masters hold and retry; BUS_RR_ARB_EN selects round-robin over data-first priority.
module bus_interconnect #(
    parameter int NUM_SLAVES = 4,
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter logic [NUM_SLAVES*ADDR_W-1:0] BASE_ADDR =
        {32'h0300_0000, 32'h0200_0000, 32'h0020_0000, 32'h0010_0000},
    parameter logic [NUM_SLAVES*ADDR_W-1:0] TOP_ADDR =
        {32'h0300_1000, 32'h0200_1000, 32'h0030_0000, 32'h0014_0000}
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [1:0]                       m_valid,
    input  logic [1:0]                       m_instr,
    input  logic [2*ADDR_W-1:0]              m_addr,
    input  logic [2*DATA_W-1:0]              m_wdata,
    input  logic [2*(DATA_W/8)-1:0]          m_wstrb,
    output logic [2*DATA_W-1:0]              m_rdata,
    output logic [1:0]                       m_ready,
    output logic [1:0]                       m_error,
    output logic [NUM_SLAVES-1:0]            s_valid,
    output logic [NUM_SLAVES-1:0]            s_instr,
    output logic [NUM_SLAVES*ADDR_W-1:0]     s_addr,
    output logic [NUM_SLAVES*DATA_W-1:0]     s_wdata,
    output logic [NUM_SLAVES*(DATA_W/8)-1:0] s_wstrb,
    input  logic [NUM_SLAVES*DATA_W-1:0]     s_rdata,
    input  logic [NUM_SLAVES-1:0]            s_ready
);
    localparam int SW     = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam int STRB_W = DATA_W / 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_ERR  = 2'd2
    } state_t;

    state_t        state0_q, state0_d, state1_q, state1_d;
    logic [SW-1:0] own0_q, own0_d, own1_q, own1_d;

    logic [SW:0]        dec0, dec1;
    logic [1:0]         hit;
    logic [SW-1:0]      idx0, idx1;
    logic [1:0]         req, blocked, gnt;
    logic               conflict;
    logic               winner;
    logic [1:0]         own_rdy;
    logic [DATA_W-1:0]  own_dat0, own_dat1;

    // Scanning downwards lets the lowest-index window win on overlap.
    function automatic logic [SW:0] decode(input logic [ADDR_W-1:0] addr);
        logic [SW:0] r;
        r = '0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if (addr >= BASE_ADDR[i*ADDR_W +: ADDR_W] && addr < TOP_ADDR[i*ADDR_W +: ADDR_W]) begin
                r = {1'b1, SW'(i)};
            end
        end
        return r;
    endfunction

    function automatic state_t next_state(input state_t cur, input logic vld, input logic hit_i,
                                          input logic gnt_i, input logic rdy_i);
        state_t nxt;
        nxt = cur;
        case (cur)
            ST_IDLE: begin
                if (vld && !hit_i) begin
                    nxt = ST_ERR;
                end else if (gnt_i) begin
                    nxt = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (rdy_i) begin
                    nxt = ST_IDLE;
                end
            end
            default: nxt = ST_IDLE;
        endcase
        return nxt;
    endfunction

    assign dec0 = decode(m_addr[ADDR_W-1:0]);
    assign dec1 = decode(m_addr[2*ADDR_W-1:ADDR_W]);
    assign hit  = {dec1[SW], dec0[SW]};
    assign idx0 = dec0[SW-1:0];
    assign idx1 = dec1[SW-1:0];

`ifdef BUS_RR_ARB_EN
    logic ptr_q, ptr_d;

    assign winner = ptr_q;

    always_comb begin
        ptr_d = ptr_q;
        if (conflict) begin
            ptr_d = ~ptr_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ptr_q <= 1'b1;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    assign winner = 1'b1;
`endif

    // A slave owned by the other master stays blocked even in its s_ready cycle.
    always_comb begin
        req[0]     = rst && (state0_q == ST_IDLE) && m_valid[0] && hit[0];
        req[1]     = rst && (state1_q == ST_IDLE) && m_valid[1] && hit[1];
        blocked[0] = (state1_q == ST_BUSY) && (own1_q == idx0);
        blocked[1] = (state0_q == ST_BUSY) && (own0_q == idx1);
        conflict   = req[0] && req[1] && (idx0 == idx1);
        gnt[0]     = req[0] && !blocked[0] && !(conflict && winner);
        gnt[1]     = req[1] && !blocked[1] && !(conflict && !winner);
    end

    always_comb begin
        own_rdy  = '0;
        own_dat0 = '0;
        own_dat1 = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (own0_q == SW'(i)) begin
                own_rdy[0] = s_ready[i];
                own_dat0   = s_rdata[i*DATA_W +: DATA_W];
            end
            if (own1_q == SW'(i)) begin
                own_rdy[1] = s_ready[i];
                own_dat1   = s_rdata[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        state0_d = next_state(state0_q, m_valid[0], hit[0], gnt[0], own_rdy[0]);
        state1_d = next_state(state1_q, m_valid[1], hit[1], gnt[1], own_rdy[1]);
        own0_d   = gnt[0] ? idx0 : own0_q;
        own1_d   = gnt[1] ? idx1 : own1_q;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state0_q <= ST_IDLE;
            state1_q <= ST_IDLE;
            own0_q   <= '0;
            own1_q   <= '0;
        end else begin
            state0_q <= state0_d;
            state1_q <= state1_d;
            own0_q   <= own0_d;
            own1_q   <= own1_d;
        end
    end

    // Responses are masked while rst is low so a late s_ready cannot leak through.
    always_comb begin
        m_ready = '0;
        m_error = '0;
        m_rdata = '0;
        if (rst) begin
            if (state0_q == ST_BUSY) begin
                m_ready[0]           = own_rdy[0];
                m_rdata[DATA_W-1:0]  = own_dat0;
            end else if (state0_q == ST_ERR) begin
                m_ready[0] = 1'b1;
                m_error[0] = 1'b1;
            end
            if (state1_q == ST_BUSY) begin
                m_ready[1]                 = own_rdy[1];
                m_rdata[2*DATA_W-1:DATA_W] = own_dat1;
            end else if (state1_q == ST_ERR) begin
                m_ready[1] = 1'b1;
                m_error[1] = 1'b1;
            end
        end
    end

    always_comb begin
        s_valid = '0;
        s_instr = '0;
        s_addr  = '0;
        s_wdata = '0;
        s_wstrb = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            s_instr[i]                    = m_instr[1];
            s_addr[i*ADDR_W +: ADDR_W]    = m_addr[ADDR_W +: ADDR_W] ^ BASE_ADDR[i*ADDR_W +: ADDR_W];
            s_wdata[i*DATA_W +: DATA_W]   = m_wdata[DATA_W +: DATA_W];
            s_wstrb[i*STRB_W +: STRB_W]   = m_wstrb[STRB_W +: STRB_W];
            if (gnt[1] && idx1 == SW'(i)) begin
                s_valid[i] = 1'b1;
            end
            if (gnt[0] && idx0 == SW'(i)) begin
                s_valid[i]                  = 1'b1;
                s_instr[i]                  = m_instr[0];
                s_addr[i*ADDR_W +: ADDR_W]  = m_addr[ADDR_W-1:0] ^ BASE_ADDR[i*ADDR_W +: ADDR_W];
                s_wdata[i*DATA_W +: DATA_W] = m_wdata[DATA_W-1:0];
                s_wstrb[i*STRB_W +: STRB_W] = m_wstrb[STRB_W-1:0];
            end
        end
    end

endmodule
